// File: rtl/led_frame_shifter.sv
// GRB frame serialiser for chained addressable LEDs. It captures a frame and
// runtime LED count on Start, then presents one bit per Advance, MSB first.
module led_frame_shifter #(
  parameter int MAX_LEDS     = 8,
  parameter int BITS_PER_LED = 24,
  parameter int CNTW         = $clog2(MAX_LEDS*BITS_PER_LED+1),
  parameter int NW           = $clog2(MAX_LEDS+1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [MAX_LEDS*BITS_PER_LED-1:0] InputBits,
  input  logic [NW-1:0]                    NumLEDs,
  input  logic                             Broadcast,
  input  logic                             Start,
  input  logic                             Advance,
  output logic                             CurrentBit,
  output logic                             BitValid,
  output logic                             Busy,
  output logic                             FrameDone
);

  localparam int TOTAL = MAX_LEDS * BITS_PER_LED;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [TOTAL-1:0]  sreg;
  logic [TOTAL-1:0]  load_data;
  logic [CNTW-1:0]   count;
  logic [CNTW-1:0]   load_count;
  logic [NW-1:0]     n_eff;

  // A zero count still sends one LED; oversize counts clamp to the frame size.
  always_comb begin
    n_eff = NumLEDs;
    if (NumLEDs == '0) begin
      n_eff = NW'(1);
    end else if (NumLEDs > NW'(MAX_LEDS)) begin
      n_eff = NW'(MAX_LEDS);
    end
  end

  always_comb begin
    load_count = CNTW'(n_eff) * CNTW'(BITS_PER_LED);
    if (Broadcast) begin
      load_data = {MAX_LEDS{InputBits[TOTAL-1 -: BITS_PER_LED]}};
    end else begin
      load_data = InputBits;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = SHIFT;
      SHIFT:   if (Advance && count == CNTW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg  <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            sreg  <= load_data;
            count <= load_count;
          end
        end
        SHIFT: begin
          if (Advance) begin
            sreg  <= sreg << 1;
            count <= count - CNTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only flopped state, so no input reaches them combinationally.
  always_comb begin
    BitValid   = (state == SHIFT);
    Busy       = (state != IDLE);
    FrameDone  = (state == DONE);
    CurrentBit = (state == SHIFT) && sreg[TOTAL-1];
  end

endmodule

// File: tb/tb_led_frame_shifter.sv
// Directed bench for led_frame_shifter with MAX_LEDS=4: a vector table of
// whole frames plus hand sequences for stalls, abort and back-to-back frames.
module tb_led_frame_shifter;

  localparam int MAXL  = 4;
  localparam int BPL   = 24;
  localparam int TOT   = MAXL * BPL;
  localparam int NWID  = $clog2(MAXL+1);
  localparam int CWID  = $clog2(TOT+1);

  logic            clk = 1'b0;
  logic            reset;
  logic [TOT-1:0]  InputBits;
  logic [NWID-1:0] NumLEDs;
  logic            Broadcast;
  logic            Start;
  logic            Advance;
  logic            CurrentBit;
  logic            BitValid;
  logic            Busy;
  logic            FrameDone;

  int checks   = 0;
  int failures = 0;

  led_frame_shifter #(
    .MAX_LEDS     (MAXL),
    .BITS_PER_LED (BPL),
    .CNTW         (CWID),
    .NW           (NWID)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .InputBits  (InputBits),
    .NumLEDs    (NumLEDs),
    .Broadcast  (Broadcast),
    .Start      (Start),
    .Advance    (Advance),
    .CurrentBit (CurrentBit),
    .BitValid   (BitValid),
    .Busy       (Busy),
    .FrameDone  (FrameDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NWID-1:0] nl;
    logic            bc;
    logic [TOT-1:0]  bits;
    int              nbits;
    logic [TOT-1:0]  exp;
    int              done_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one frame: Start pulsed once, bits captured whenever BitValid and
  // Advance coincide. mode 1 stalls Advance and disturbs inputs mid-frame.
  task automatic do_frame(input string tag, input logic [NWID-1:0] nl, input logic bc,
                          input logic [TOT-1:0] bits, input int mode,
                          output int nbits, output logic [TOT-1:0] stream,
                          output int done_cnt, output int done_cyc, output int busy_low);
    int cyc;
    logic pat[4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    nbits = 0; stream = '0; done_cnt = 0; done_cyc = -1; busy_low = -1;
    @(negedge clk);
    InputBits = bits; NumLEDs = nl; Broadcast = bc; Start = 1'b1; Advance = 1'b0;
    @(negedge clk);
    Start = 1'b0;
    cyc = 1;
    chk({tag, " first_valid"}, TOT'({Busy, BitValid}), TOT'(2'b11));
    while (cyc < 500) begin
      if (mode == 1) begin
        Advance = pat[cyc % 4];
        if ($urandom_range(0, 3) == 0) Advance = 1'b0;
        Start = (cyc == 5);
        if (cyc == 7) begin
          InputBits = ~bits; NumLEDs = NWID'(1); Broadcast = ~bc;
        end
      end else begin
        Advance = 1'b1;
      end
      if (FrameDone) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!Busy) begin
        busy_low = cyc;
        break;
      end
      if (BitValid && Advance) begin
        stream = {stream[TOT-2:0], CurrentBit};
        nbits++;
      end
      @(negedge clk);
      cyc++;
    end
    Start = 1'b0;
    Advance = 1'b0;
    chk({tag, " timeout"}, TOT'(cyc >= 500), TOT'(0));
  endtask

  int             nb, dc, dcy, bl;
  logic [TOT-1:0] st;
  int             idle_cnt, done_a, done_b, bb_bits;
  logic [TOT-1:0] bb_stream;

  initial begin
    vecs[0] = '{nl: 3'd2, bc: 1'b0, bits: 96'hFF0000_00AA55_123456_789ABC,
                nbits: 48, exp: 96'hFF000000AA55, done_cyc: 49};
    vecs[1] = '{nl: 3'd3, bc: 1'b1, bits: 96'h0F0F0F_FFFFFF_FFFFFF_FFFFFF,
                nbits: 72, exp: 96'h0F0F0F_0F0F0F_0F0F0F, done_cyc: 73};
    vecs[2] = '{nl: 3'd0, bc: 1'b0, bits: 96'hA5C3E1_FFFFFF_FFFFFF_FFFFFF,
                nbits: 24, exp: 96'hA5C3E1, done_cyc: 25};
    vecs[3] = '{nl: 3'd7, bc: 1'b0, bits: 96'h111111_222222_333333_444444,
                nbits: 96, exp: 96'h111111_222222_333333_444444, done_cyc: 97};
    vecs[4] = '{nl: 3'd4, bc: 1'b1, bits: 96'h800001_7E7E7E_000000_FFFFFF,
                nbits: 96, exp: 96'h800001_800001_800001_800001, done_cyc: 97};
    vecs[5] = '{nl: 3'd1, bc: 1'b1, bits: 96'hC00003_555555_AAAAAA_0F0F0F,
                nbits: 24, exp: 96'hC00003, done_cyc: 25};

    reset = 1'b1; Start = 1'b0; Advance = 1'b0; Broadcast = 1'b0;
    NumLEDs = '0; InputBits = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", TOT'({CurrentBit, BitValid, Busy, FrameDone}), TOT'(0));
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_frame($sformatf("vec%0d", i), vecs[i].nl, vecs[i].bc, vecs[i].bits, 0, nb, st, dc, dcy, bl);
      chk($sformatf("vec%0d nbits", i), TOT'(nb), TOT'(vecs[i].nbits));
      chk($sformatf("vec%0d stream", i), st, vecs[i].exp);
      chk($sformatf("vec%0d done_count", i), TOT'(dc), TOT'(1));
      chk($sformatf("vec%0d done_cycle", i), TOT'(dcy), TOT'(vecs[i].done_cyc));
      chk($sformatf("vec%0d busy_low", i), TOT'(bl), TOT'(vecs[i].done_cyc + 1));
    end

    // Stalled Advance with mid-frame Start and input changes.
    do_frame("stall", 3'd2, 1'b0, 96'hFF0000_00AA55_123456_789ABC, 1, nb, st, dc, dcy, bl);
    chk("stall nbits", TOT'(nb), TOT'(48));
    chk("stall stream", st, 96'hFF000000AA55);
    chk("stall done_count", TOT'(dc), TOT'(1));
    @(negedge clk);
    chk("stall no_restart", TOT'(Busy), TOT'(0));

    // Reset after 10 bits of a 48-bit frame.
    @(negedge clk);
    InputBits = 96'hFF0000_00AA55_000000_000000; NumLEDs = 3'd2; Broadcast = 1'b0;
    Start = 1'b1; Advance = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort mid_busy", TOT'(Busy), TOT'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("abort outputs", TOT'({CurrentBit, BitValid, Busy, FrameDone}), TOT'(0));
    @(negedge clk);
    chk("abort no_done", TOT'(FrameDone), TOT'(0));
    reset = 1'b0; Advance = 1'b0;
    do_frame("after_abort", 3'd2, 1'b0, 96'h3C5A96_E70001_000000_000000, 0, nb, st, dc, dcy, bl);
    chk("after_abort stream", st, 96'h3C5A96E70001);
    chk("after_abort nbits", TOT'(nb), TOT'(48));

    // Start and reset together: reset wins.
    @(negedge clk);
    reset = 1'b1; Start = 1'b1;
    @(negedge clk);
    chk("start_reset busy", TOT'({Busy, BitValid}), TOT'(0));
    reset = 1'b0; Start = 1'b0;
    @(negedge clk);
    chk("start_reset idle", TOT'(Busy), TOT'(0));

    // Start held: one DONE and one IDLE cycle between 24-bit frames.
    idle_cnt = 0; done_a = -1; done_b = -1; bb_bits = 0; bb_stream = '0;
    InputBits = 96'hA5C3E1_000000_000000_000000; NumLEDs = 3'd1; Broadcast = 1'b0;
    Start = 1'b1; Advance = 1'b1;
    for (int c = 1; c <= 51; c++) begin
      @(negedge clk);
      if (FrameDone) begin
        if (done_a < 0) done_a = c;
        else done_b = c;
      end
      if (!Busy) idle_cnt++;
      if (BitValid) begin
        bb_stream = {bb_stream[TOT-2:0], CurrentBit};
        bb_bits++;
      end
    end
    Start = 1'b0; Advance = 1'b0;
    chk("b2b done_first", TOT'(done_a), TOT'(25));
    chk("b2b done_second", TOT'(done_b), TOT'(51));
    chk("b2b idle_cycles", TOT'(idle_cnt), TOT'(1));
    chk("b2b nbits", TOT'(bb_bits), TOT'(48));
    chk("b2b stream", bb_stream, 96'hA5C3E1A5C3E1);
    repeat (2) @(negedge clk);
    chk("b2b final_idle", TOT'(Busy), TOT'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_frame_shifter.md
# led_frame_shifter

Parametrised GRB frame serialiser for chained addressable-LED modules. Captures a frame of up to MAX_LEDS 24-bit colour words and a runtime LED count, then presents one bit at a time, MSB-first, to the downstream bit-timing encoder under an advance handshake. Unlike the fixed five-LED shift register, it supports any LED count up to MAX_LEDS, a broadcast mode, explicit frame-done signalling and busy gating. It sits between the colour/switch front end and the pulse-width encoder.

## Interface
- MAX_LEDS, 8, maximum LEDs per frame (≥1)
- BITS_PER_LED, 24, colour bits per LED (GRB, G MSB)
- CNTW, $clog2(MAX_LEDS*BITS_PER_LED+1), bit-counter width
- NW, $clog2(MAX_LEDS+1), LED-count width
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- InputBits  input  MAX_LEDS*BITS_PER_LED  frame data; LED0 in the top BITS_PER_LED bits
- NumLEDs  input  NW  runtime LED count; sampled only on accepted Start
- Broadcast  input  1  1 = send LED0 colour to every LED; sampled with Start
- Start  input  1  request a new frame
- Advance  input  1  encoder consumed CurrentBit; move to next bit
- CurrentBit  output  1  bit being transmitted
- BitValid  output  1  CurrentBit is valid
- Busy  output  1  frame in progress (SHIFT or DONE)
- FrameDone  output  1  one-cycle pulse after last bit consumed

## Operation
- States: IDLE, SHIFT, DONE. Reset → IDLE.
- Reset values: CurrentBit 0, BitValid 0, Busy 0, FrameDone 0, bit counter 0, shift register 0.
- IDLE: Start=1 → SHIFT. Same edge: latch effective count N = 1 if NumLEDs=0, MAX_LEDS if NumLEDs>MAX_LEDS, else NumLEDs; counter ← N*BITS_PER_LED.
- Load: Broadcast=0 → register ← InputBits (LED0 at MSB); Broadcast=1 → register ← LED0 word replicated into all MAX_LEDS slots. Only the top N*BITS_PER_LED bits are transmitted.
- SHIFT: BitValid=1, CurrentBit=register MSB. Advance=1 → register shifts left one, zero filled; counter decrements. Advance when counter=1 → DONE.
- DONE: one cycle; FrameDone=1, BitValid=0, Busy=1; → IDLE unconditionally.
- Start in SHIFT or DONE ignored; InputBits/NumLEDs/Broadcast changes after acceptance have no effect on the frame.
- Advance with BitValid=0 ignored.
- Reset in any state aborts frame immediately: next cycle IDLE, all outputs at reset values, no FrameDone.
- Start and reset together: reset wins.
- Counter arithmetic unsigned, CNTW bits; N*BITS_PER_LED never overflows by construction.

## Timing
- Start accepted at edge t → Busy=1, BitValid=1, CurrentBit = bit 0 (LED0 MSB) from cycle t+1.
- Each Advance at edge k → next bit visible at k+1; zero-bubble back-to-back Advance gives one bit per cycle.
- Last Advance at edge u → FrameDone=1 and BitValid=0 during cycle u+1; IDLE from u+2, Busy=0.
- Earliest new Start accepted at edge u+2; minimum frame period N*BITS_PER_LED+2 cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- MAX_LEDS=4, NumLEDs=2, Broadcast=0, InputBits top 48 = 24'hFF0000,24'h00AA55, Advance held 1 → CurrentBit sequence FF0000 then 00AA55 MSB-first over 48 cycles, FrameDone pulse at cycle 49 after Start, Busy low at 50.
- NumLEDs=3, Broadcast=1, LED0=24'h0F0F0F, other slots 24'hFFFFFF → 72 bits = 0F0F0F repeated three times; no FFFFFF bits appear.
- NumLEDs=0 → exactly 24 bits sent; NumLEDs=7 with MAX_LEDS=4 → exactly 96 bits sent.
- Advance toggled 1,0,0,1 with random gaps, InputBits changed mid-frame, Start pulsed mid-frame → bit stream unchanged from captured frame, one FrameDone only, extra Start ignored.
- Reset asserted after 10 bits of a 48-bit frame → next cycle BitValid=0, Busy=0, CurrentBit=0, no FrameDone; following Start sends full new frame from bit 0.
- Start held continuously → frames back-to-back with exactly one DONE cycle and one IDLE cycle between them.
